// File: rtl/fir_result_tx_pkg.sv
// Shared constants and types for the FIR result serial transmitter.
package fir_result_tx_pkg;

  // 50 MHz system clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Top-level byte sequencing states.
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_SEND = 2'd1;
  localparam logic [1:0] TX_DONE = 2'd2;

  // Per-byte frame states; BIT_IDLE means no frame on the line.
  localparam logic [1:0] BIT_IDLE  = 2'd0;
  localparam logic [1:0] BIT_START = 2'd1;
  localparam logic [1:0] BIT_DATA  = 2'd2;
  localparam logic [1:0] BIT_STOP  = 2'd3;

  // Request from the sequencer to the byte transmitter.
  typedef struct packed {
    logic       start;
    logic [7:0] data;
  } byte_req_t;

endpackage

// File: rtl/fir_result_tx_if.sv
// FIR result handshake plus serial-side status, shared by the source and transmitter.
interface fir_result_tx_if #(
  parameter int DATA_W = 16
);
  logic              output_valid;
  logic [DATA_W-1:0] fir_out;
  logic              tx_ready;
  logic              tx_serial;
  logic              tx_busy;
  logic              tx_done;
  logic              overrun;

  // FIR datapath side: offers results, observes transmitter status.
  modport master (
    output output_valid, fir_out,
    input  tx_ready, tx_serial, tx_busy, tx_done, overrun
  );

  // Transmitter side.
  modport slave (
    input  output_valid, fir_out,
    output tx_ready, tx_serial, tx_busy, tx_done, overrun
  );
endinterface

// File: rtl/fir_result_tx_byte.sv
// Bit-serial byte transmitter: start bit, 8 data bits LSB first, stop bit.
// A start request seen on the last cycle of a stop bit chains the next frame
// with no idle bit in between.
module uart_tx_byte
  import fir_result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx_serial,
  output logic       busy,
  output logic       byte_done
);
  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_wrap;

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign byte_done = (r_state == BIT_STOP) && w_wrap;
  assign busy      = (r_state != BIT_IDLE);
  assign tx_serial = r_tx;

  // Baud counter: free-runs 0..CLKS_PER_BIT-1 while a frame is on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_cnt <= '0;
    else if (r_state == BIT_IDLE || w_wrap) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  // Frame FSM; the serial output is a register so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= BIT_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        BIT_IDLE: begin
          if (start) begin
            r_shift <= data;
            r_tx    <= 1'b0;
            r_state <= BIT_START;
          end
        end
        BIT_START: begin
          if (w_wrap) begin
            r_tx      <= r_shift[0];
            r_bit_idx <= '0;
            r_state   <= BIT_DATA;
          end
        end
        BIT_DATA: begin
          if (w_wrap) begin
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= BIT_STOP;
            end else begin
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        BIT_STOP: begin
          if (w_wrap) begin
            if (start) begin
              // Back-to-back byte: stop bit flows straight into the next start bit.
              r_shift <= data;
              r_tx    <= 1'b0;
              r_state <= BIT_START;
            end else begin
              r_state <= BIT_IDLE;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= BIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/fir_result_tx.sv
// Captures one FIR result and sends it LSB byte first over a UART-style line.
// Holds the frozen result word, the byte index and the byte-sequencing FSM.
module fir_result_tx
  import fir_result_tx_pkg::*;
#(
  parameter int DATA_W       = 16,  // multiple of 8
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT  // >= 2
)(
  input  logic           clk,
  input  logic           rst,
  fir_result_tx_if.slave bus
);
  localparam int               NUM_BYTES = DATA_W / 8;
  localparam int               IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_byte_idx;
  logic              r_ov_flag;
  logic              r_overrun;

  logic [DATA_W-1:0] w_word_nxt;
  logic              w_last;
  logic              w_byte_busy;
  logic              w_byte_done;
  logic              w_tx_serial;
  byte_req_t         w_req;

  // Byte request: the first byte starts from an idle transmitter, later bytes
  // are handed over on the stop-bit's final cycle so they chain seamlessly.
  always_comb begin
    w_last      = (r_byte_idx == LAST_IDX);
    w_word_nxt  = r_word >> 8;
    w_req.start = (r_state == TX_SEND) &&
                  (!w_byte_busy || (w_byte_done && !w_last));
    w_req.data  = w_byte_done ? w_word_nxt[7:0] : r_word[7:0];
  end

  // Sequencer: capture in IDLE, walk the bytes in SEND, one-cycle DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= TX_IDLE;
      r_word     <= '0;
      r_byte_idx <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (bus.output_valid) begin
            r_word     <= bus.fir_out;
            r_byte_idx <= '0;
            r_state    <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (w_byte_done) begin
            if (w_last) begin
              r_state <= TX_DONE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_word     <= w_word_nxt;
            end
          end
        end
        TX_DONE: r_state <= TX_IDLE;
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  // Overrun: one pulse per burst of output_valid seen outside IDLE. The flag
  // survives a capture so a level held high across frames reports only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ov_flag <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_state != TX_IDLE) && bus.output_valid && !r_ov_flag;
      if (!bus.output_valid)         r_ov_flag <= 1'b0;
      else if (r_state != TX_IDLE)   r_ov_flag <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .start    (w_req.start),
    .data     (w_req.data),
    .tx_serial(w_tx_serial),
    .busy     (w_byte_busy),
    .byte_done(w_byte_done)
  );

  assign bus.tx_ready  = (r_state == TX_IDLE);
  assign bus.tx_done   = (r_state == TX_DONE);
  assign bus.tx_busy   = w_byte_busy;
  assign bus.tx_serial = w_tx_serial;
  assign bus.overrun   = r_overrun;

endmodule
